// File: rtl/avmm_pio_poller_if.sv
// ---------------------------------------------------------------------------
// avmm_pio_poller_if
//   Read-only Avalon-MM link between the PIO poller (master) and a
//   fixed-latency PIO slave with registered readdata and no readdatavalid.
//
//   avm_address      master -> slave  ADDR_W  read address
//   avm_read         master -> slave  1       read request
//   avm_waitrequest  slave -> master  1       stall; read accepted when low
//   avm_readdata     slave -> master  32      read data
// ---------------------------------------------------------------------------
interface avmm_pio_poller_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/avmm_pio_poller.sv
// ---------------------------------------------------------------------------
// avmm_pio_poller
//   Periodically reads a PIO input slave over Avalon-MM, debounces the
//   sampled bits over consecutive reads and publishes a stable value plus a
//   one-cycle change event.
//
//   clk           in   1       clock
//   reset_n       in   1       asynchronous active-low reset
//   enable        in   1       1 = polling active
//   avm           master modport of avmm_pio_poller_if (address/read/
//                 waitrequest/readdata)
//   value_out     out  DATA_W  last accepted (debounced) value
//   value_valid   out  1       sticky: a value has been accepted since reset
//   change_pulse  out  1       one-cycle pulse when value_out updates
//   changed_bits  out  DATA_W  old ^ new of the last update
//
//   The interface instance must be built with the same ADDR_W as this module.
// ---------------------------------------------------------------------------
module avmm_pio_poller #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 2,
    parameter int POLL_ADDR    = 0,
    parameter int POLL_PERIOD  = 50000,
    parameter int READ_LATENCY = 1,
    parameter int STABLE_COUNT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    avmm_pio_poller_if.master avm,
    output logic [DATA_W-1:0] value_out,
    output logic              value_valid,
    output logic              change_pulse,
    output logic [DATA_W-1:0] changed_bits
);

    localparam int TMR_W = $clog2(POLL_PERIOD);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t            state_q,      state_d;
    logic [TMR_W-1:0]  timer_q,      timer_d;
    logic              pending_q,    pending_d;
    logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;
    logic [DATA_W-1:0] sample_q,     sample_d;
    logic [DATA_W-1:0] candidate_q,  candidate_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [DATA_W-1:0] value_q,      value_d;
    logic              valid_q,      valid_d;
    logic              pulse_q,      pulse_d;
    logic [DATA_W-1:0] changed_q,    changed_d;
    logic              read_q,       read_d;

    logic tick;
    logic consume;

    // Only readdata[DATA_W-1:0] carries switch state; the rest is ignored.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avm.avm_readdata};

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        lat_cnt_d    = lat_cnt_q;
        sample_d     = sample_q;
        candidate_d  = candidate_q;
        stable_cnt_d = stable_cnt_q;
        value_d      = value_q;
        valid_d      = valid_q;
        pulse_d      = 1'b0;
        changed_d    = changed_q;
        tick         = 1'b0;
        consume      = 1'b0;

        // Poll timer: free-runs while enabled, parked at reload otherwise.
        if (!enable) begin
            timer_d = TMR_RELOAD;
        end else if (timer_q == '0) begin
            timer_d = TMR_RELOAD;
            tick    = 1'b1;
        end else begin
            timer_d = timer_q - TMR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // enable is re-checked so a request left over from the cycle
                // in which enable fell never starts a read.
                if (pending_q && enable) begin
                    consume = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!avm.avm_waitrequest) begin
                    lat_cnt_d = LAT_RELOAD;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) begin
                    sample_d = avm.avm_readdata[DATA_W-1:0];
                    state_d  = S_EVAL;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_EVAL: begin
                if (sample_q == candidate_q) begin
                    stable_cnt_d = (stable_cnt_q == CNT_MAX) ? CNT_MAX
                                                             : stable_cnt_q + CNT_W'(1);
                end else begin
                    candidate_d  = sample_q;
                    stable_cnt_d = CNT_W'(1);
                end
                // Accepting an unchanged value is silent; the very first
                // acceptance always publishes, even when the value is 0.
                if ((stable_cnt_d == CNT_MAX) && (!valid_q || (candidate_d != value_q))) begin
                    value_d   = candidate_d;
                    changed_d = value_q ^ candidate_d;
                    valid_d   = 1'b1;
                    pulse_d   = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A tick arriving while a request is already pending merges with it.
        pending_d = (pending_q && !consume) || tick;
        if (!enable) begin
            pending_d = 1'b0;
        end

        read_d = (state_d == S_READ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= TMR_RELOAD;
            pending_q    <= 1'b0;
            lat_cnt_q    <= '0;
            sample_q     <= '0;
            candidate_q  <= '0;
            stable_cnt_q <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            pulse_q      <= 1'b0;
            changed_q    <= '0;
            read_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            lat_cnt_q    <= lat_cnt_d;
            sample_q     <= sample_d;
            candidate_q  <= candidate_d;
            stable_cnt_q <= stable_cnt_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            pulse_q      <= pulse_d;
            changed_q    <= changed_d;
            read_q       <= read_d;
        end
    end

    assign avm.avm_address = ADDR_W'(POLL_ADDR);
    assign avm.avm_read    = read_q;
    assign value_out       = value_q;
    assign value_valid     = valid_q;
    assign change_pulse    = pulse_q;
    assign changed_bits    = changed_q;

endmodule

// File: tb/tb_avmm_pio_poller.sv
// ---------------------------------------------------------------------------
// tb_avmm_pio_poller
//   Directed bench for avmm_pio_poller with a registered PIO slave model.
//   Expected change events are queued by the stimulus and consumed by a
//   monitor whenever change_pulse is seen.
// ---------------------------------------------------------------------------
module tb_avmm_pio_poller;

    localparam int DATA_W    = 4;
    localparam int ADDR_W    = 2;
    localparam int POLL_ADDR = 2;
    localparam int PERIOD    = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              wr = 1'b0;
    logic [DATA_W-1:0] sw = '0;
    logic [DATA_W-1:0] value_out;
    logic              value_valid;
    logic              change_pulse;
    logic [DATA_W-1:0] changed_bits;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] changed;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    avmm_pio_poller_if #(.ADDR_W(ADDR_W)) avm_if ();

    assign avm_if.avm_waitrequest = wr;

    avmm_pio_poller #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .POLL_ADDR   (POLL_ADDR),
        .POLL_PERIOD (PERIOD),
        .READ_LATENCY(1),
        .STABLE_COUNT(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .avm         (avm_if.master),
        .value_out   (value_out),
        .value_valid (value_valid),
        .change_pulse(change_pulse),
        .changed_bits(changed_bits)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered PIO slave: readdata captured on the accepting edge; upper
    // bits filled with junk the DUT must ignore.
    always @(posedge clk) begin
        if (avm_if.avm_read && !avm_if.avm_waitrequest) begin
            avm_if.avm_readdata <= {28'hABCDEF1, sw};
            acc_cnt             <= acc_cnt + 1;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && change_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(change_pulse), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_value", 32'(value_out), 32'(mon_e.value));
                chk("pulse_changed", 32'(changed_bits), 32'(mon_e.changed));
                chk("pulse_valid", 32'(value_valid), 32'd1);
                $display("event: value_out=%0h changed_bits=%0h", value_out, changed_bits);
            end
        end
    end

    // Returns at the negedge after the accepting edge; t is the cycle index
    // of the accepting cycle.
    task automatic wait_accept(output int t);
        bit ok = 1'b0;
        t = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (avm_if.avm_read && !avm_if.avm_waitrequest) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        chk("read_accept_timeout", 32'(ok), 32'd1);
        if (ok) begin
            @(negedge clk);
            $display("read accepted: cycle=%0d sw=%0h", t, sw);
        end
    endtask

    task automatic wait_read();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (avm_if.avm_read) ok = 1'b1;
        end
        chk("read_request_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_read(input logic [DATA_W-1:0] v, output int t);
        sw = v;
        wait_accept(t);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, t4;
        int acc_before;
        int rd_seen;
        bit held_ok;
        logic [DATA_W-1:0] p3 [7];
        p3 = '{4'hA, 4'hA, 4'hA, 4'h5, 4'hA, 4'hA, 4'hA};

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(avm_if.avm_read), 32'd0);
        chk("rst_addr", 32'(avm_if.avm_address), 32'(POLL_ADDR));
        chk("rst_value", 32'(value_out), 32'd0);
        chk("rst_valid", 32'(value_valid), 32'd0);
        chk("rst_pulse", 32'(change_pulse), 32'd0);
        chk("rst_changed", 32'(changed_bits), 32'd0);

        // 2: constant A, one read per period, accept on 3rd read
        reset_n = 1'b1;
        enable  = 1'b1;
        do_read(4'hA, t1);
        do_read(4'hA, t2);
        exp_q.push_back('{value: 4'hA, changed: 4'hA});
        do_read(4'hA, t3);
        chk("poll_interval_a", 32'(t3 - t2), 32'(PERIOD));
        do_read(4'hA, t4);
        chk("poll_interval_b", 32'(t4 - t3), 32'(PERIOD));
        repeat (4) @(negedge clk);
        chk("p2_value", 32'(value_out), 32'hA);
        chk("p2_valid", 32'(value_valid), 32'd1);
        chk("p2_events_done", 32'(exp_q.size()), 32'd0);

        // 3: glitch to 5 does not disturb the accepted value
        foreach (p3[i]) do_read(p3[i], t1);
        repeat (4) @(negedge clk);
        chk("p3_value", 32'(value_out), 32'hA);
        chk("p3_changed_held", 32'(changed_bits), 32'hA);

        // 4: A -> 3
        do_read(4'h3, t1);
        do_read(4'h3, t1);
        exp_q.push_back('{value: 4'h3, changed: 4'h9});
        do_read(4'h3, t1);
        repeat (4) @(negedge clk);
        chk("p4_value", 32'(value_out), 32'h3);
        chk("p4_events_done", 32'(exp_q.size()), 32'd0);

        // 5: stalled read, ticks collapse into one pending read
        acc_before = acc_cnt;
        wr = 1'b1;
        wait_read();
        held_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (avm_if.avm_read !== 1'b1 || avm_if.avm_address !== ADDR_W'(POLL_ADDR))
                held_ok = 1'b0;
        end
        chk("stall_held", 32'(held_ok), 32'd1);
        chk("stall_no_accept", 32'(acc_cnt - acc_before), 32'd0);
        t1 = cyc;
        wr = 1'b0;
        @(negedge clk);
        chk("stall_one_accept", 32'(acc_cnt - acc_before), 32'd1);
        $display("read accepted: cycle=%0d sw=%0h (after stall)", t1, sw);
        wait_accept(t2);
        chk("collapsed_read_gap", 32'(t2 - t1), 32'd4);
        wait_accept(t3);
        chk("no_queued_ticks", 32'(t3 - t2 > 4), 32'd1);

        // 6a: enable drops during READ
        wait_read();
        acc_before = acc_cnt;
        enable = 1'b0;
        rd_seen = 0;
        repeat (3 * PERIOD + 8) begin
            @(negedge clk);
            if (avm_if.avm_read) rd_seen++;
        end
        chk("disable_completes", 32'(acc_cnt - acc_before), 32'd1);
        chk("disable_no_reads", 32'(rd_seen), 32'd0);
        chk("disable_value", 32'(value_out), 32'h3);

        // 6b: reset mid-WAIT, then first acceptance of 0
        enable = 1'b1;
        do_read(4'h3, t1);
        reset_n = 1'b0;
        #1;
        chk("midrst_read", 32'(avm_if.avm_read), 32'd0);
        chk("midrst_value", 32'(value_out), 32'd0);
        chk("midrst_valid", 32'(value_valid), 32'd0);
        chk("midrst_pulse", 32'(change_pulse), 32'd0);
        chk("midrst_changed", 32'(changed_bits), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_read(4'h0, t1);
        do_read(4'h0, t1);
        exp_q.push_back('{value: 4'h0, changed: 4'h0});
        do_read(4'h0, t1);
        repeat (4) @(negedge clk);
        chk("zero_valid", 32'(value_valid), 32'd1);
        chk("final_events_done", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
